bridge_frame_initiator: RTL and testbench
=========================================

# bridge_frame_initiator

Bus-B-side initiator of the UART bus bridge. It consumes the byte stream recovered by the bridge's UART receiver and decodes 3- or 4-byte command frames. Each frame becomes one single-byte read or write on Bus B, using the standard initiator handshake, including split support. The response byte goes back to the UART transmitter: read data for a read, an ACK byte for a write.

## Interface
Parameters:
- SYNC_HDR, 7'h55: required value of header bits [7:1]
- ACK_BYTE, 8'h06: response byte for a completed write
- TIMEOUT_CYCLES, 100000: inter-byte frame timeout; used only when FRAME_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_byte  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- tx_byte  out  8  response byte
- tx_valid  out  1  response valid, held until accepted
- tx_ready  in  1  UART transmitter can accept
- rx_drop  out  1  one-cycle pulse: byte discarded (bad header, or arrived while busy)
- init_req  out  1  bus request
- init_grant  in  1  arbiter grant
- init_addr_out  out  16  transaction address
- init_addr_out_valid  out  1  address phase valid
- init_data_out  out  8  write data
- init_data_out_valid  out  1  write data valid
- init_rw  out  1  1 = write, 0 = read
- init_ready  out  1  initiator ready to accept read data
- init_ack  in  1  target accepted the address phase
- init_split_ack  in  1  target split the transaction
- init_data_in  in  8  read data
- init_data_in_valid  in  1  read data strobe

## Operation
Frame format:
- Byte 0 is the header: bits[7:1] must equal SYNC_HDR; bit0 = rw.
- Bytes 1 and 2 are the address, high byte then low byte.
- Byte 3 (write frames only) is the data.

States: S_HDR, S_AH, S_AL, S_DATA, S_REQ, S_XFER, S_SPLIT, S_RESP.
- S_HDR: on rx_valid:
  - Header match: latch rw, go to S_AH.
  - Mismatch: pulse rx_drop, stay in S_HDR.
- S_AH: on rx_valid, latch addr[15:8], go to S_AL.
- S_AL: on rx_valid, latch addr[7:0]. Go to S_DATA if rw = 1, else S_REQ.
- S_DATA: on rx_valid, latch data, go to S_REQ.
- S_REQ: assert init_req; on init_grant go to S_XFER.
- S_XFER: hold init_req, init_addr_out_valid, init_rw, init_addr_out; for writes also init_data_out and init_data_out_valid.
  - Write, on init_ack: response = ACK_BYTE, go to S_RESP.
  - Read: init_ready = 1.
    - On init_data_in_valid: capture init_data_in as the response, go to S_RESP.
    - Else on init_split_ack: go to S_SPLIT.
- S_SPLIT: drop init_req and all valids; keep init_ready = 1.
  - On init_data_in_valid: capture data, go to S_RESP.
- S_RESP: tx_valid = 1 with the latched tx_byte.
  - On tx_ready: go to S_HDR.

Boundary conditions:
- rx_valid in S_REQ, S_XFER, S_SPLIT or S_RESP: byte discarded, rx_drop pulses.
- Simultaneous init_ack and init_data_in_valid on a read: data wins, and the transfer completes.
- init_grant deasserted in S_XFER before completion: return to S_REQ and reissue.
- Reset mid-operation: immediate return to S_HDR. All outputs go low, and the frame is lost.

## Timing
- All outputs are registered.
- Reset value 0 for every output, including init_addr_out, init_data_out and tx_byte.
- The last frame byte's rx_valid moves the FSM to S_REQ on the following edge.
- init_req is high in the cycle after the last frame byte.
- Grant to address-phase valid: 1 cycle.
- Address-phase outputs stay stable until completion or split.
- Completion to tx_valid: 1 cycle.
- tx_valid drops in the cycle after the tx_ready acceptance.
- Back-to-back frames are accepted once the FSM is in S_HDR.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - A counter runs in S_AH, S_AL and S_DATA, and clears on each rx_valid.
  - Reaching TIMEOUT_CYCLES-1 returns the FSM to S_HDR and pulses rx_drop.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- FRAME_TIMEOUT_EN undefined: no counter, and a partial frame waits indefinitely.

## Structure
- Package bridge_frame_pkg holds:
  - the state enum typedef
  - SYNC_HDR and ACK_BYTE default constants
  - frame length localparams (3 for read, 4 for write)
- Sub-module bridge_frame_parser covers S_HDR through S_DATA and the timeout. It emits a single-cycle cmd_valid with cmd_rw, cmd_addr and cmd_data.
- The top module holds the bus and response FSM.

## Test plan
- Write frame: rx bytes AB,12,34,5C; immediate grant and ack → bus write addr 16'h1234 data 8'h5C; tx_byte 8'h06.
- Read frame: rx AA,80,04; target returns 8'hA5 two cycles after grant → tx_byte 8'hA5; init_ready high until data.
- Split read: init_split_ack after the address phase → init_req low. Data 8'h3C arrives 50 cycles later → tx_byte 8'h3C.
- Bad header: rx 8'hFF then a valid read frame → one rx_drop pulse; the read still completes correctly.
- Busy drop: extra rx byte during S_XFER → rx_drop pulse; transaction unaffected; tx_valid held 10 cycles with tx_ready low, byte unchanged.
- With FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - rx AB,12 then silence → return to S_HDR after 16 cycles, rx_drop pulses.
  - Reset asserted in S_SPLIT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/bridge_frame_pkg.sv
// bridge_frame_pkg: shared types and constants for the UART bus bridge
// frame initiator.
//   state_t       - FSM state encoding (parser states S_HDR..S_DATA,
//                   bus/response states S_REQ..S_RESP)
//   SYNC_HDR_DEF  - default required value of header bits [7:1]
//   ACK_BYTE_DEF  - default response byte for a completed write
//   FRAME_LEN_*   - frame lengths in bytes
package bridge_frame_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_AH,
    S_AL,
    S_DATA,
    S_REQ,
    S_XFER,
    S_SPLIT,
    S_RESP
  } state_t;

  localparam logic [6:0]  SYNC_HDR_DEF = 7'h55;
  localparam logic [7:0]  ACK_BYTE_DEF = 8'h06;
  localparam int unsigned FRAME_LEN_RD = 3;
  localparam int unsigned FRAME_LEN_WR = 4;

endpackage

// File: rtl/bridge_frame_parser.sv
// bridge_frame_parser: decodes 3-byte read / 4-byte write command frames
// from the UART receive byte stream.
// Optional feature: FRAME_TIMEOUT_EN (inter-byte frame timeout).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   rx_byte_i     - received byte
//   rx_valid_i    - one-cycle strobe for rx_byte_i
//   busy_i        - bus side busy; bytes are ignored (top reports the drop)
//   cmd_valid_o   - single-cycle strobe, complete frame decoded
//   cmd_rw_o      - 1 = write, 0 = read
//   cmd_addr_o    - 16-bit address
//   cmd_data_o    - write data
//   drop_o        - one-cycle: bad header or frame timeout
module bridge_frame_parser
  import bridge_frame_pkg::*;
#(
  parameter logic [6:0]  SYNC_HDR       = SYNC_HDR_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  input  logic        busy_i,
  output logic        cmd_valid_o,
  output logic        cmd_rw_o,
  output logic [15:0] cmd_addr_o,
  output logic [7:0]  cmd_data_o,
  output logic        drop_o
);

  state_t      state_q, state_d;
  logic        rw_q;
  logic [7:0]  addr_hi_q, addr_lo_q;
  logic        rx_fire;
  logic        hdr_ok;
  logic        timeout;

  assign rx_fire = rx_valid_i & ~busy_i;
  assign hdr_ok  = (rx_byte_i[7:1] == SYNC_HDR);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  logic             in_frame;

  assign in_frame = (state_q == S_AH) || (state_q == S_AL) || (state_q == S_DATA);
  assign timeout  = in_frame && !rx_fire && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt_q <= '0;
    else if (!in_frame || rx_fire || timeout) cnt_q <= '0;
    else                                    cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR:   if (rx_fire && hdr_ok) state_d = S_AH;
      S_AH:    if (rx_fire) state_d = S_AL;
      S_AL:    if (rx_fire) state_d = rw_q ? S_DATA : S_HDR;
      S_DATA:  if (rx_fire) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
    if (timeout) state_d = S_HDR;
  end

  // The last byte is forwarded combinationally so the top can register the
  // command on the same edge that consumes it.
  always_comb begin
    cmd_valid_o = rx_fire && (((state_q == S_AL) && !rw_q) || (state_q == S_DATA));
    drop_o      = (rx_fire && (state_q == S_HDR) && !hdr_ok) || timeout;
    cmd_rw_o    = rw_q;
    cmd_addr_o  = {addr_hi_q, (state_q == S_AL) ? rx_byte_i : addr_lo_q};
    cmd_data_o  = rx_byte_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q      <= 1'b0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
    end else if (rx_fire) begin
      case (state_q)
        S_HDR:   if (hdr_ok) rw_q <= rx_byte_i[0];
        S_AH:    addr_hi_q <= rx_byte_i;
        S_AL:    addr_lo_q <= rx_byte_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bridge_frame_initiator.sv
// bridge_frame_initiator: Bus-B initiator of the UART bus bridge. Turns each
// decoded frame into one single-byte bus read/write (with split support) and
// returns read data or ACK_BYTE to the UART transmitter.
// Optional feature: FRAME_TIMEOUT_EN (handled in bridge_frame_parser).
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   rx_byte, rx_valid           - UART receive byte stream
//   tx_byte, tx_valid, tx_ready - response byte handshake
//   rx_drop                     - one-cycle pulse, byte discarded
//   init_req/init_grant         - bus request / arbiter grant
//   init_addr_out(_valid), init_data_out(_valid), init_rw - address phase
//   init_ready                  - ready to accept read data
//   init_ack, init_split_ack    - target response to address phase
//   init_data_in(_valid)        - read data return
// All outputs are registered and reset to zero.
module bridge_frame_initiator
  import bridge_frame_pkg::*;
#(
  parameter logic [6:0]  SYNC_HDR       = SYNC_HDR_DEF,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        rx_drop,
  output logic        init_req,
  input  logic        init_grant,
  output logic [15:0] init_addr_out,
  output logic        init_addr_out_valid,
  output logic [7:0]  init_data_out,
  output logic        init_data_out_valid,
  output logic        init_rw,
  output logic        init_ready,
  input  logic        init_ack,
  input  logic        init_split_ack,
  input  logic [7:0]  init_data_in,
  input  logic        init_data_in_valid
);

  state_t      state_q, state_d;
  logic        busy;
  logic        cmd_valid, cmd_rw, p_drop;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rw_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;

  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rx_drop_q, rx_drop_d;
  logic        init_req_q, init_req_d;
  logic [15:0] init_addr_out_q, init_addr_out_d;
  logic        init_addr_out_valid_q, init_addr_out_valid_d;
  logic [7:0]  init_data_out_q, init_data_out_d;
  logic        init_data_out_valid_q, init_data_out_valid_d;
  logic        init_rw_q, init_rw_d;
  logic        init_ready_q, init_ready_d;

  assign busy = (state_q != S_HDR);

  bridge_frame_parser #(
    .SYNC_HDR       (SYNC_HDR),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte_i   (rx_byte),
    .rx_valid_i  (rx_valid),
    .busy_i      (busy),
    .cmd_valid_o (cmd_valid),
    .cmd_rw_o    (cmd_rw),
    .cmd_addr_o  (cmd_addr),
    .cmd_data_o  (cmd_data),
    .drop_o      (p_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR:   if (cmd_valid) state_d = S_REQ;
      S_REQ:   if (init_grant) state_d = S_XFER;
      S_XFER: begin
        if (rw_q) begin
          if (init_ack)         state_d = S_RESP;
          else if (!init_grant) state_d = S_REQ;
        end else begin
          // Read data takes priority over a coincident ack or split.
          if (init_data_in_valid)  state_d = S_RESP;
          else if (init_split_ack) state_d = S_SPLIT;
          else if (!init_grant)    state_d = S_REQ;
        end
      end
      S_SPLIT: if (init_data_in_valid) state_d = S_RESP;
      S_RESP:  if (tx_ready) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    init_req_d            = (state_d == S_REQ) || (state_d == S_XFER);
    init_addr_out_valid_d = (state_d == S_XFER);
    init_addr_out_d       = (state_d == S_XFER) ? addr_q : '0;
    init_rw_d             = (state_d == S_XFER) && rw_q;
    init_data_out_valid_d = (state_d == S_XFER) && rw_q;
    init_data_out_d       = ((state_d == S_XFER) && rw_q) ? data_q : '0;
    init_ready_d          = ((state_d == S_XFER) && !rw_q) || (state_d == S_SPLIT);
    tx_valid_d            = (state_d == S_RESP);
    tx_byte_d             = tx_byte_q;
    if ((state_d == S_RESP) && (state_q != S_RESP))
      tx_byte_d = rw_q ? ACK_BYTE : init_data_in;
    rx_drop_d             = p_drop || (rx_valid && busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q                  <= 1'b0;
      addr_q                <= '0;
      data_q                <= '0;
      tx_byte_q             <= '0;
      tx_valid_q            <= 1'b0;
      rx_drop_q             <= 1'b0;
      init_req_q            <= 1'b0;
      init_addr_out_q       <= '0;
      init_addr_out_valid_q <= 1'b0;
      init_data_out_q       <= '0;
      init_data_out_valid_q <= 1'b0;
      init_rw_q             <= 1'b0;
      init_ready_q          <= 1'b0;
    end else begin
      if ((state_q == S_HDR) && cmd_valid) begin
        rw_q   <= cmd_rw;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
      tx_byte_q             <= tx_byte_d;
      tx_valid_q            <= tx_valid_d;
      rx_drop_q             <= rx_drop_d;
      init_req_q            <= init_req_d;
      init_addr_out_q       <= init_addr_out_d;
      init_addr_out_valid_q <= init_addr_out_valid_d;
      init_data_out_q       <= init_data_out_d;
      init_data_out_valid_q <= init_data_out_valid_d;
      init_rw_q             <= init_rw_d;
      init_ready_q          <= init_ready_d;
    end
  end

  assign tx_byte             = tx_byte_q;
  assign tx_valid            = tx_valid_q;
  assign rx_drop             = rx_drop_q;
  assign init_req            = init_req_q;
  assign init_addr_out       = init_addr_out_q;
  assign init_addr_out_valid = init_addr_out_valid_q;
  assign init_data_out       = init_data_out_q;
  assign init_data_out_valid = init_data_out_valid_q;
  assign init_rw             = init_rw_q;
  assign init_ready          = init_ready_q;

endmodule

// File: tb/tb_bridge_frame_initiator.sv
// Directed testbench for bridge_frame_initiator. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
module tb_bridge_frame_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        rx_drop;
  logic        init_req;
  logic        init_grant = 1'b0;
  logic [15:0] init_addr_out;
  logic        init_addr_out_valid;
  logic [7:0]  init_data_out;
  logic        init_data_out_valid;
  logic        init_rw;
  logic        init_ready;
  logic        init_ack = 1'b0;
  logic        init_split_ack = 1'b0;
  logic [7:0]  init_data_in = '0;
  logic        init_data_in_valid = 1'b0;

  int tests = 0;
  int fails = 0;
  int drop_cnt = 0;

  logic [38:0] all_o;
  assign all_o = {tx_byte, tx_valid, rx_drop, init_req, init_addr_out, init_addr_out_valid,
                  init_data_out, init_data_out_valid, init_rw, init_ready};

  bridge_frame_initiator #(
    .SYNC_HDR       (7'h55),
    .ACK_BYTE       (8'h06),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_byte             (rx_byte),
    .rx_valid            (rx_valid),
    .tx_byte             (tx_byte),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .rx_drop             (rx_drop),
    .init_req            (init_req),
    .init_grant          (init_grant),
    .init_addr_out       (init_addr_out),
    .init_addr_out_valid (init_addr_out_valid),
    .init_data_out       (init_data_out),
    .init_data_out_valid (init_data_out_valid),
    .init_rw             (init_rw),
    .init_ready          (init_ready),
    .init_ack            (init_ack),
    .init_split_ack      (init_split_ack),
    .init_data_in        (init_data_in),
    .init_data_in_valid  (init_data_in_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_drop === 1'b1) drop_cnt++;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Sends n bytes from the top of 'bytes' (MSB first).
  task automatic send_bytes(input logic [31:0] bytes, input int n);
    logic [31:0] v;
    v = bytes;
    for (int i = 0; i < n; i++) begin
      send_byte(v[31:24]);
      v = v << 8;
    end
  endtask

  task automatic accept_tx();
    @(negedge clk); tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (all_o !== 39'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", all_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    init_grant = 1'b1; init_ack = 1'b1;
    send_bytes(32'hAB12345C, 4);
    @(negedge clk);
    tests++;
    if ({init_req, init_addr_out_valid} !== 2'b10) begin
      fails++; $display("FAIL wr_req: req/aval got %b want 10", {init_req, init_addr_out_valid});
    end
    @(negedge clk);
    tests++;
    if ({init_addr_out, init_data_out, init_addr_out_valid, init_data_out_valid, init_rw, init_ready}
        !== {16'h1234, 8'h5C, 4'b1110}) begin
      fails++; $display("FAIL wr_xfer: addr %h data %h flags %b want 1234 5c 1110", init_addr_out,
                        init_data_out, {init_addr_out_valid, init_data_out_valid, init_rw, init_ready});
    end
    @(negedge clk);
    init_ack = 1'b0; init_grant = 1'b0;
    tests++;
    if ({tx_valid, tx_byte, init_req} !== {1'b1, 8'h06, 1'b0}) begin
      fails++; $display("FAIL wr_resp: tx_valid %b tx_byte %h req %b want 1 06 0", tx_valid, tx_byte, init_req);
    end
    tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL wr_tx_drop: tx_valid %b want 0", tx_valid);
    end
  endtask

  task automatic test_read();
    init_grant = 1'b1;
    send_bytes(32'hAA800400, 3);
    @(negedge clk);
    tests++;
    if (init_req !== 1'b1) begin
      fails++; $display("FAIL rd_req: init_req %b want 1", init_req);
    end
    @(negedge clk);
    tests++;
    if ({init_addr_out, init_addr_out_valid, init_rw, init_data_out_valid, init_ready}
        !== {16'h8004, 4'b1001}) begin
      fails++; $display("FAIL rd_xfer: addr %h flags %b want 8004 1001", init_addr_out,
                        {init_addr_out_valid, init_rw, init_data_out_valid, init_ready});
    end
    init_ack = 1'b1;
    @(negedge clk);
    init_ack = 1'b0;
    init_data_in = 8'hA5; init_data_in_valid = 1'b1;
    tests++;
    if ({init_ready, tx_valid} !== 2'b10) begin
      fails++; $display("FAIL rd_wait: ready/tx_valid %b want 10", {init_ready, tx_valid});
    end
    @(negedge clk);
    init_data_in_valid = 1'b0; init_grant = 1'b0;
    tests++;
    if ({tx_valid, tx_byte, init_ready, init_req} !== {1'b1, 8'hA5, 2'b00}) begin
      fails++; $display("FAIL rd_resp: tx_valid %b tx_byte %h ready %b req %b want 1 a5 0 0",
                        tx_valid, tx_byte, init_ready, init_req);
    end
    accept_tx();
  endtask

  task automatic test_ack_data_same();
    init_grant = 1'b1;
    send_bytes(32'hAA00F000, 3);
    repeat (2) @(negedge clk);
    init_ack = 1'b1; init_data_in = 8'h77; init_data_in_valid = 1'b1;
    @(negedge clk);
    init_ack = 1'b0; init_data_in_valid = 1'b0; init_grant = 1'b0;
    tests++;
    if ({tx_valid, tx_byte} !== {1'b1, 8'h77}) begin
      fails++; $display("FAIL ack_data_same: tx_valid %b tx_byte %h want 1 77", tx_valid, tx_byte);
    end
    accept_tx();
  endtask

  task automatic test_split();
    int bad;
    init_grant = 1'b1;
    send_bytes(32'hAA001000, 3);
    repeat (2) @(negedge clk);
    init_split_ack = 1'b1;
    @(negedge clk);
    init_split_ack = 1'b0; init_grant = 1'b0;
    tests++;
    if ({init_req, init_addr_out_valid, init_ready} !== 3'b001) begin
      fails++; $display("FAIL split_enter: req/aval/ready %b want 001", {init_req, init_addr_out_valid, init_ready});
    end
    bad = 0;
    repeat (49) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || init_ready !== 1'b1 || init_req !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL split_hold: %0d bad cycles want 0", bad);
    end
    init_data_in = 8'h3C; init_data_in_valid = 1'b1;
    @(negedge clk);
    init_data_in_valid = 1'b0;
    tests++;
    if ({tx_valid, tx_byte, init_ready} !== {1'b1, 8'h3C, 1'b0}) begin
      fails++; $display("FAIL split_resp: tx_valid %b tx_byte %h ready %b want 1 3c 0", tx_valid, tx_byte, init_ready);
    end
    accept_tx();
  endtask

  task automatic test_bad_header();
    int d0;
    d0 = drop_cnt;
    init_grant = 1'b1;
    send_byte(8'hFF);
    send_bytes(32'hAA002000, 3);
    repeat (2) @(negedge clk);
    init_data_in = 8'h5A; init_data_in_valid = 1'b1;
    @(negedge clk);
    init_data_in_valid = 1'b0; init_grant = 1'b0;
    tests++;
    if ({tx_valid, tx_byte} !== {1'b1, 8'h5A}) begin
      fails++; $display("FAIL badhdr_read: tx_valid %b tx_byte %h want 1 5a", tx_valid, tx_byte);
    end
    tests++;
    if (drop_cnt - d0 != 1) begin
      fails++; $display("FAIL badhdr_drop: drops %0d want 1", drop_cnt - d0);
    end
    accept_tx();
  endtask

  task automatic test_busy_drop();
    int d0, bad;
    init_grant = 1'b1;
    send_bytes(32'hAB004099, 4);
    repeat (2) @(negedge clk);
    d0 = drop_cnt;
    send_byte(8'h11);
    repeat (2) @(negedge clk);
    tests++;
    if (drop_cnt - d0 != 1) begin
      fails++; $display("FAIL busy_drop: drops %0d want 1", drop_cnt - d0);
    end
    tests++;
    if ({init_addr_out, init_data_out, init_addr_out_valid, init_data_out_valid, init_rw}
        !== {16'h0040, 8'h99, 3'b111}) begin
      fails++; $display("FAIL busy_xfer: addr %h data %h flags %b want 0040 99 111", init_addr_out,
                        init_data_out, {init_addr_out_valid, init_data_out_valid, init_rw});
    end
    init_ack = 1'b1;
    @(negedge clk);
    init_ack = 1'b0; init_grant = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_byte !== 8'h06) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL busy_tx_hold: %0d bad cycles want 0", bad);
    end
    tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL busy_tx_done: tx_valid %b want 0", tx_valid);
    end
  endtask

  task automatic test_grant_loss();
    init_grant = 1'b1;
    send_bytes(32'hAA120000, 3);
    repeat (2) @(negedge clk);
    init_grant = 1'b0;
    @(negedge clk);
    tests++;
    if ({init_req, init_addr_out_valid} !== 2'b10) begin
      fails++; $display("FAIL gloss_req: req/aval %b want 10", {init_req, init_addr_out_valid});
    end
    init_grant = 1'b1;
    @(negedge clk);
    tests++;
    if ({init_addr_out_valid, init_addr_out} !== {1'b1, 16'h1200}) begin
      fails++; $display("FAIL gloss_reissue: aval %b addr %h want 1 1200", init_addr_out_valid, init_addr_out);
    end
    init_data_in = 8'h42; init_data_in_valid = 1'b1;
    @(negedge clk);
    init_data_in_valid = 1'b0; init_grant = 1'b0;
    tests++;
    if ({tx_valid, tx_byte} !== {1'b1, 8'h42}) begin
      fails++; $display("FAIL gloss_resp: tx_valid %b tx_byte %h want 1 42", tx_valid, tx_byte);
    end
    accept_tx();
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout();
    int d0;
    d0 = drop_cnt;
    send_bytes(32'hAB120000, 2);
    repeat (20) @(negedge clk);
    tests++;
    if (drop_cnt - d0 != 1) begin
      fails++; $display("FAIL timeout_drop: drops %0d want 1", drop_cnt - d0);
    end
    init_grant = 1'b1;
    send_bytes(32'hAA000100, 3);
    repeat (2) @(negedge clk);
    init_data_in = 8'h81; init_data_in_valid = 1'b1;
    @(negedge clk);
    init_data_in_valid = 1'b0; init_grant = 1'b0;
    tests++;
    if ({tx_valid, tx_byte} !== {1'b1, 8'h81}) begin
      fails++; $display("FAIL timeout_next: tx_valid %b tx_byte %h want 1 81", tx_valid, tx_byte);
    end
    accept_tx();
  endtask
`else
  task automatic test_timeout();
    int d0;
    d0 = drop_cnt;
    send_bytes(32'hAB120000, 2);
    repeat (40) @(negedge clk);
    tests++;
    if (drop_cnt - d0 != 0 || init_req !== 1'b0) begin
      fails++; $display("FAIL no_timeout: drops %0d req %b want 0 0", drop_cnt - d0, init_req);
    end
    init_grant = 1'b1; init_ack = 1'b1;
    send_bytes(32'h345C0000, 2);
    repeat (3) @(negedge clk);
    init_ack = 1'b0; init_grant = 1'b0;
    tests++;
    if ({tx_valid, tx_byte} !== {1'b1, 8'h06}) begin
      fails++; $display("FAIL no_timeout_resume: tx_valid %b tx_byte %h want 1 06", tx_valid, tx_byte);
    end
    accept_tx();
  endtask
`endif

  task automatic test_reset_mid();
    init_grant = 1'b1;
    send_bytes(32'hAA00AA00, 3);
    repeat (2) @(negedge clk);
    init_split_ack = 1'b1;
    @(negedge clk);
    init_split_ack = 1'b0; init_grant = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (all_o !== 39'd0) begin
      fails++; $display("FAIL reset_mid: got %h want 0", all_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ack_data_same();
    test_split();
    test_bad_header();
    test_busy_drop();
    test_grant_loss();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
